// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM encoding and ASCII constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEND    = 3'd1,
        WAIT_HI = 3'd2,
        WAIT_LO = 3'd3,
        NEXT    = 3'd4
    } state_t;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_CR = 8'h0D;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NREQ = 2,
    parameter int PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic [NREQ-1:0] gnt_next,
    output logic            valid
);

    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;
    logic [NREQ-1:0]   rot_gnt;
    logic [2*NREQ-1:0] dbl_gnt;

    // Rotate so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        dbl     = {req, req} >> ptr;
        rot     = dbl[NREQ-1:0];
        rot_gnt = '0;
        valid   = 1'b0;
        for (int j = 0; j < NREQ; j++) begin
            if (!valid && rot[j]) begin
                rot_gnt[j] = 1'b1;
                valid      = 1'b1;
            end
        end
        dbl_gnt  = {rot_gnt, rot_gnt} << ptr;
        gnt_next = dbl_gnt[2*NREQ-1:NREQ];
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin message arbiter in front of the single TransmitData serializer.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NREQ         = 2,
    parameter int BUSY_TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ-1:0]   last,
    input  logic [8*NREQ-1:0] data,
    output logic [NREQ-1:0]   ack,
    output logic [NREQ-1:0]   grant,
    output logic              txdStart,
    output logic [7:0]        txdData,
    input  logic              txdBusy,
    output logic              busy,
    output logic              timeout_err
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BUSY_TIMEOUT + 1);

    state_t            state_q, state_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   ack_q, ack_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     gidx_q, gidx_d;
    logic              txd_start_q, txd_start_d;
    logic [7:0]        txd_data_q, txd_data_d;
    logic              lastflag_q, lastflag_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              tmo_q, tmo_d;
    logic              busy_q, busy_d;

    logic [NREQ-1:0]   gnt_next;
    logic              gnt_valid;
    logic [PW-1:0]     pick_idx;
    logic [7:0]        bytes [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_bytes
        assign bytes[i] = data[8*i +: 8];
    end

    rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_rr (
        .req      (req),
        .ptr      (ptr_q),
        .gnt_next (gnt_next),
        .valid    (gnt_valid)
    );

    // One-hot pick to index, so the holder can address its byte lane.
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_next[i]) pick_idx = PW'(i);
        end
    end

    // Next-state and registered-output logic; pulses default low every cycle.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        ack_d       = '0;
        ptr_d       = ptr_q;
        gidx_d      = gidx_q;
        txd_start_d = 1'b0;
        txd_data_d  = txd_data_q;
        lastflag_d  = lastflag_q;
        cnt_d       = cnt_q;
        tmo_d       = 1'b0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant_d = gnt_next;
                    gidx_d  = pick_idx;
                    state_d = SEND;
                end
            end
            SEND: begin
                txd_data_d  = bytes[gidx_q];
                txd_start_d = 1'b1;
                ack_d       = grant_q;
                lastflag_d  = last[gidx_q];
                cnt_d       = '0;
                state_d     = WAIT_HI;
            end
            WAIT_HI: begin
                if (txdBusy) begin
                    state_d = WAIT_LO;
                end else if (cnt_q == CW'(BUSY_TIMEOUT - 1)) begin
                    // Serializer never answered; treat the byte as sent so the message can finish.
                    tmo_d   = 1'b1;
                    state_d = NEXT;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LO: begin
                if (!txdBusy) state_d = NEXT;
            end
            NEXT: begin
                if (lastflag_q) begin
                    grant_d = '0;
                    ptr_d   = (gidx_q == PW'(NREQ - 1)) ? '0 : gidx_q + 1'b1;
                    state_d = IDLE;
                end else if (req[gidx_q]) begin
                    state_d = SEND;
                end
                // Otherwise the holder keeps the UART until it supplies the rest of its message.
            end
            default: state_d = IDLE;
        endcase
        busy_d = |grant_d;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            ack_q       <= '0;
            ptr_q       <= '0;
            gidx_q      <= '0;
            txd_start_q <= 1'b0;
            txd_data_q  <= 8'h00;
            lastflag_q  <= 1'b0;
            cnt_q       <= '0;
            tmo_q       <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            ack_q       <= ack_d;
            ptr_q       <= ptr_d;
            gidx_q      <= gidx_d;
            txd_start_q <= txd_start_d;
            txd_data_q  <= txd_data_d;
            lastflag_q  <= lastflag_d;
            cnt_q       <= cnt_d;
            tmo_q       <= tmo_d;
            busy_q      <= busy_d;
        end
    end

    assign grant       = grant_q;
    assign ack         = ack_q;
    assign txdStart    = txd_start_q;
    assign txdData     = txd_data_q;
    assign busy        = busy_q;
    assign timeout_err = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple TransmitData model.
module tb_uart_tx_arbiter;
    import uart_pkg::*;

    localparam int NREQ = 2;
    localparam int BT   = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req, last, ack, grant;
    logic [15:0] data;
    logic        txdStart;
    logic [7:0]  txdData;
    logic        txdBusy = 1'b0;
    logic        busy, timeout_err;

    always #5 clk = ~clk;

    uart_tx_arbiter #(.NREQ(NREQ), .BUSY_TIMEOUT(BT)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .last        (last),
        .data        (data),
        .ack         (ack),
        .grant       (grant),
        .txdStart    (txdStart),
        .txdData     (txdData),
        .txdBusy     (txdBusy),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    // TransmitData model: busy rises one cycle after txdStart and stays high 10 cycles.
    logic model_en;
    int   bcnt = 0;
    always @(posedge clk) begin
        if (reset) begin
            txdBusy <= 1'b0;
            bcnt    <= 0;
        end else if (txdStart && model_en) begin
            txdBusy <= 1'b1;
            bcnt    <= 10;
        end else if (bcnt > 0) begin
            bcnt <= bcnt - 1;
            if (bcnt == 1) txdBusy <= 1'b0;
        end
    end

    // Event monitor: start log, grant history, handshake sanity.
    logic [1:0] st_g[$];
    logic [7:0] st_d[$];
    logic [1:0] gh[$];
    logic [1:0] last_g = 2'b00;
    int ack_viol = 0;
    int tmo_cnt  = 0;
    always @(negedge clk) begin
        if (!reset) begin
            if (txdStart) begin
                st_g.push_back(grant);
                st_d.push_back(txdData);
            end
            if ((ack != 2'b00) != txdStart) ack_viol++;
            if (timeout_err) tmo_cnt++;
            if (grant != last_g) gh.push_back(grant);
            last_g = grant;
        end
    end

    int n_cmp = 0;
    int n_mis = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        st_g.delete();
        st_d.delete();
        gh.delete();
    endtask

    logic [8:0] q0[$];
    logic [8:0] q1[$];

    // Present queued {last,byte} items on each requester, popping on ack, until all sent and idle.
    task automatic service(input int max_cyc, input string tag);
        bit done;
        done = 1'b0;
        for (int c = 0; c < max_cyc && !done; c++) begin
            req[0] = (q0.size() != 0);
            req[1] = (q1.size() != 0);
            if (q0.size() != 0) begin data[7:0]  = q0[0][7:0]; last[0] = q0[0][8]; end
            if (q1.size() != 0) begin data[15:8] = q1[0][7:0]; last[1] = q1[0][8]; end
            tick();
            if (ack[0] && q0.size() != 0) void'(q0.pop_front());
            if (ack[1] && q1.size() != 0) void'(q1.pop_front());
            if (q0.size() == 0 && q1.size() == 0 && req == 2'b00 && grant == 2'b00) done = 1'b1;
            if (q0.size() == 0) req[0] = 1'b0;
            if (q1.size() == 0) req[1] = 1'b0;
        end
        req = 2'b00;
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic chk_start(input string tag, input int i, input logic [1:0] g, input logic [7:0] d);
        if (st_g.size() > i) begin
            chk({tag, "_g"}, 32'(st_g[i]), 32'(g));
            chk({tag, "_d"}, 32'(st_d[i]), 32'(d));
        end else begin
            chk({tag, "_present"}, 32'(st_g.size()), 32'(i + 1));
        end
    endtask

    int c;
    int bad;

    initial begin
        req = 2'b00; last = 2'b00; data = 16'h0000; model_en = 1'b1; reset = 1'b1;
        repeat (3) tick();
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_ack",   32'(ack),   32'd0);
        chk("rst_start", 32'(txdStart), 32'd0);
        chk("rst_data",  32'(txdData), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk("rst_tmo",   32'(timeout_err), 32'd0);
        reset = 1'b0;
        tick();

        // 1: single byte from requester 0
        clear_logs();
        req = 2'b01; data[7:0] = 8'h35; last = 2'b01;
        tick();
        chk("t1_grant_n1", 32'(grant), 32'h1);
        chk("t1_nostart_n1", 32'(txdStart), 32'd0);
        tick();
        chk("t1_start", 32'(txdStart), 32'd1);
        chk("t1_ack",   32'(ack), 32'h1);
        chk("t1_data",  32'(txdData), 32'h35);
        chk("t1_busy",  32'(busy), 32'd1);
        req = 2'b00;
        c = 0;
        while (grant != 2'b00 && c < 50) begin tick(); c++; end
        chk("t1_rel_lat", 32'(c), 32'd13);
        chk("t1_busy_off", 32'(busy), 32'd0);

        // 2: three-byte message on 1 while 0 waits (ptr is now 1)
        tick();
        clear_logs();
        q1 = {9'h031, 9'h032, 9'h10D};
        q0 = {9'h145};
        service(300, "t2");
        chk_start("t2_b0", 0, 2'b10, ASCII_0 + 8'h01);
        chk_start("t2_b1", 1, 2'b10, 8'h32);
        chk_start("t2_b2", 2, 2'b10, ASCII_CR);
        chk_start("t2_b3", 3, 2'b01, ASCII_E);
        chk("t2_gh_len", 32'(gh.size() >= 3), 32'd1);
        if (gh.size() >= 3) begin
            chk("t2_gh0", 32'(gh[0]), 32'h2);
            chk("t2_gh1", 32'(gh[1]), 32'h0);
            chk("t2_gh2", 32'(gh[2]), 32'h1);
        end

        // 3: fairness from a fresh pointer
        reset = 1'b1; tick(); reset = 1'b0; tick();
        clear_logs();
        q0 = {9'h141, 9'h142};
        q1 = {9'h151, 9'h152};
        service(300, "t3");
        chk_start("t3_m0", 0, 2'b01, 8'h41);
        chk_start("t3_m1", 1, 2'b10, 8'h51);
        chk_start("t3_m2", 2, 2'b01, 8'h42);
        chk_start("t3_m3", 3, 2'b10, 8'h52);

        // 4: serializer never goes busy
        tick();
        model_en = 1'b0;
        req = 2'b01; data[7:0] = 8'h55; last = 2'b01;
        c = 0;
        while (!txdStart && c < 10) begin tick(); c++; end
        chk("t4_start", 32'(txdStart), 32'd1);
        req = 2'b00;
        c = 0;
        while (!timeout_err && c < 40) begin tick(); c++; end
        chk("t4_tmo_lat", 32'(c), 32'(BT));
        tick();
        chk("t4_tmo_pulse", 32'(timeout_err), 32'd0);
        chk("t4_idle", 32'(grant), 32'd0);
        model_en = 1'b1;
        tick();

        // 5: holder stalls mid-message while 1 requests (ptr is now 1, so 0 asks alone first)
        req = 2'b01; data[7:0] = 8'h41; last = 2'b00;
        c = 0;
        while (ack != 2'b01 && c < 10) begin tick(); c++; end
        chk("t5_ack0", 32'(ack), 32'h1);
        req = 2'b10; data[15:8] = 8'h42; last = 2'b10;
        bad = 0;
        repeat (40) begin
            tick();
            if (grant != 2'b01 || txdStart) bad++;
        end
        chk("t5_stall", 32'(bad), 32'd0);
        req = 2'b11; data[7:0] = 8'h43; last = 2'b11;
        c = 0;
        while (!txdStart && c < 10) begin tick(); c++; end
        chk("t5_resume_g", 32'(grant), 32'h1);
        chk("t5_resume_d", 32'(txdData), 32'h43);
        req[0] = 1'b0;
        c = 0;
        while (ack != 2'b10 && c < 60) begin tick(); c++; end
        chk("t5_serve1_g", 32'(grant), 32'h2);
        chk("t5_serve1_d", 32'(txdData), 32'h42);
        req = 2'b00;
        c = 0;
        while (grant != 2'b00 && c < 40) begin tick(); c++; end
        chk("t5_idle", 32'(grant), 32'd0);

        // 6: reset while waiting for busy to fall, pointer moved to 1 beforehand
        tick();
        q0 = {9'h160};
        service(60, "t6a");
        req = 2'b01; data[7:0] = 8'h61; last = 2'b01;
        c = 0;
        while (!txdStart && c < 10) begin tick(); c++; end
        req = 2'b00;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk("t6_grant", 32'(grant), 32'd0);
        chk("t6_start", 32'(txdStart), 32'd0);
        chk("t6_data",  32'(txdData), 32'd0);
        chk("t6_busy",  32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        clear_logs();
        q0 = {9'h170};
        q1 = {9'h171};
        service(100, "t6b");
        chk_start("t6_m0", 0, 2'b01, 8'h70);
        chk_start("t6_m1", 1, 2'b10, 8'h71);

        chk("ack_vs_start", 32'(ack_viol), 32'd0);
        chk("tmo_count", 32'(tmo_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
